// File: rtl/rgb_pl9823_pkg.sv
// Shared types and default timing for the PL9823 / WS281x chain driver.
// Optional brightness scaling is enabled with `define RGB_PL9823_BRIGHTNESS_EN.
package rgb_pl9823_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PIX = 2'd1,
    SEND     = 2'd2,
    GAP      = 2'd3
  } state_t;

  // Default bit timing for a 50 MHz clock.
  localparam int unsigned DEF_T_BIT   = 86;
  localparam int unsigned DEF_T0H     = 18;
  localparam int unsigned DEF_T1H     = 68;
  localparam int unsigned DEF_T_RESET = 3000;

  localparam int unsigned PIX_W = 24;

  typedef struct packed {
    logic [7:0] rot;
    logic [7:0] gruen;
    logic [7:0] blau;
  } pixel_t;

  // c * (b + 1) / 256 with a 16-bit product; b = 255 is identity.
  function automatic logic [7:0] scale_comp(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/rgb_pl9823_chain_if.sv
// Pixel stream valid/ready interface between pixel source and chain driver.
interface rgb_pl9823_chain_if;
  import rgb_pl9823_pkg::*;

  pixel_t data;
  logic   valid;
  logic   ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rgb_pl9823_bitcell.sv
// One-wire bit cell generator: a start strobe begins a T_BIT-cycle cell whose
// high time depends on the bit value; last_c flags the final cycle of a cell.
module rgb_pl9823_bitcell
  import rgb_pl9823_pkg::*;
#(
  parameter int unsigned T_BIT = DEF_T_BIT,
  parameter int unsigned T0H   = DEF_T0H,
  parameter int unsigned T1H   = DEF_T1H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_val,
  output logic out,
  output logic last_c
);

  localparam int unsigned CW = $clog2(T_BIT);

  logic [CW-1:0] ctr_q;
  logic [CW-1:0] high_q;
  logic          active_q;

  assign last_c = active_q && (ctr_q == CW'(T_BIT - 1));

  // Cell counter and registered line level; a new start may follow the last cycle directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q    <= '0;
      high_q   <= '0;
      active_q <= 1'b0;
      out      <= 1'b0;
    end else if (start) begin
      ctr_q    <= '0;
      high_q   <= bit_val ? CW'(T1H) : CW'(T0H);
      active_q <= 1'b1;
      out      <= 1'b1;
    end else if (active_q) begin
      if (last_c) begin
        ctr_q    <= '0;
        active_q <= 1'b0;
        out      <= 1'b0;
      end else begin
        ctr_q <= ctr_q + CW'(1);
        out   <= ((ctr_q + CW'(1)) < high_q);
      end
    end
  end

endmodule

// File: rtl/rgb_pl9823_chain.sv
// Parametrised PL9823 / WS281x LED chain driver: accepts N_LEDS pixels per frame
// over a valid/ready stream, serialises them MSB first, then holds a latch gap.
// Define RGB_PL9823_BRIGHTNESS_EN to scale each component by (BRIGHT+1)/256.
module rgb_pl9823_chain
  import rgb_pl9823_pkg::*;
#(
  parameter int unsigned N_LEDS  = 3,
  parameter int unsigned T_BIT   = DEF_T_BIT,
  parameter int unsigned T0H     = DEF_T0H,
  parameter int unsigned T1H     = DEF_T1H,
  parameter int unsigned T_RESET = DEF_T_RESET
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         bright,
  rgb_pl9823_chain_if.slave  pix,
  output logic               out,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun
);

  localparam int unsigned PCW      = $clog2(N_LEDS + 1);
  localparam int unsigned GCW      = $clog2(T_RESET + 1);
  localparam int unsigned BCW      = $clog2(PIX_W);
  localparam int unsigned LAST_BIT = PIX_W - 1;

  state_t             state_q;
  pixel_t             hold_q;
  logic               hold_full_q;
  logic [PIX_W-1:0]   sh_q;
  logic [PIX_W-1:0]   xfer_px;
  logic [BCW-1:0]     bit_idx_q;
  logic [PCW-1:0]     req_q;
  logic [GCW-1:0]     gap_q;
  logic               ready_q;

  logic cell_last_c;
  logic cell_start_c;
  logic cell_bit_c;
  logic accept_c;
  logic boundary_c;
  logic drain_c;
  logic adv_c;
  logic under_c;
  logic end_c;

  assign pix.ready = ready_q;

`ifdef RGB_PL9823_BRIGHTNESS_EN
  // Brightness is applied as the pixel leaves the hold register.
  assign xfer_px = {scale_comp(hold_q.rot, bright),
                    scale_comp(hold_q.gruen, bright),
                    scale_comp(hold_q.blau, bright)};
`else
  logic unused_bright;
  assign xfer_px       = hold_q;
  assign unused_bright = ^bright;
`endif

  // Per-cycle decisions: stream transfer, pixel boundary outcome, next bit cell.
  always_comb begin
    accept_c     = pix.valid && ready_q;
    boundary_c   = (state_q == SEND) && cell_last_c && (bit_idx_q == BCW'(LAST_BIT));
    drain_c      = hold_full_q && ((state_q == WAIT_PIX) || boundary_c);
    adv_c        = (state_q == SEND) && cell_last_c && (bit_idx_q != BCW'(LAST_BIT));
    under_c      = boundary_c && !hold_full_q && (req_q != PCW'(N_LEDS));
    end_c        = boundary_c && !hold_full_q && (req_q == PCW'(N_LEDS));
    cell_start_c = drain_c || adv_c;
    cell_bit_c   = drain_c ? xfer_px[LAST_BIT] : sh_q[LAST_BIT-1];
  end

  rgb_pl9823_bitcell #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_cell (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (cell_start_c),
    .bit_val (cell_bit_c),
    .out     (out),
    .last_c  (cell_last_c)
  );

  // Frame FSM with hold/shift buffering, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      bit_idx_q   <= '0;
      req_q       <= '0;
      gap_q       <= '0;
      ready_q     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;

      if (accept_c) begin
        hold_q      <= pix.data;
        hold_full_q <= 1'b1;
        req_q       <= req_q + PCW'(1);
        ready_q     <= 1'b0;
      end

      if (drain_c) begin
        sh_q        <= xfer_px;
        hold_full_q <= 1'b0;
        bit_idx_q   <= '0;
        ready_q     <= (req_q < PCW'(N_LEDS));
      end

      if (adv_c) begin
        sh_q      <= {sh_q[LAST_BIT-1:0], 1'b0};
        bit_idx_q <= bit_idx_q + BCW'(1);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= WAIT_PIX;
            busy        <= 1'b1;
            ready_q     <= 1'b1;
            req_q       <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
          end
        end
        WAIT_PIX: begin
          if (drain_c) begin
            state_q <= SEND;
          end
        end
        SEND: begin
          if (end_c || under_c) begin
            state_q <= GAP;
            gap_q   <= '0;
          end
          // An aborted frame requests nothing more; a pixel arriving this cycle is dropped.
          if (under_c) begin
            underrun    <= 1'b1;
            req_q       <= PCW'(N_LEDS);
            ready_q     <= 1'b0;
            hold_full_q <= 1'b0;
          end
        end
        GAP: begin
          if (gap_q == GCW'(T_RESET - 1)) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            gap_q <= gap_q + GCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_pl9823_chain.sv
// Scoreboard bench for rgb_pl9823_chain: expected pixels are queued at transfer
// and compared against pixels decoded from the serial line.
module tb_rgb_pl9823_chain;
  import rgb_pl9823_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned TB = 10;
  localparam int unsigned T0 = 3;
  localparam int unsigned T1 = 7;
  localparam int unsigned TR = 20;
  localparam int unsigned FRAME_LEN = N * 24 * TB + TR;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [7:0] bright = 8'd255;
  logic       out;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  rgb_pl9823_chain_if pix_if ();

  rgb_pl9823_chain #(
    .N_LEDS  (N),
    .T_BIT   (TB),
    .T0H     (T0),
    .T1H     (T1),
    .T_RESET (TR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bright     (bright),
    .pix        (pix_if.slave),
    .out        (out),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [23:0] exp_q[$];

  function automatic logic [23:0] model(input logic [23:0] p);
    logic [23:0] r;
    r = p;
`ifdef RGB_PL9823_BRIGHTNESS_EN
    for (int k = 0; k < 3; k++)
      r[k*8 +: 8] = 8'((int'(p[k*8 +: 8]) * (int'(bright) + 1)) / 256);
`endif
    return r;
  endfunction

  // Line monitor state.
  logic        prev_out = 1'b0;
  logic        after_under = 1'b0;
  logic        bitv;
  logic [23:0] word = '0;
  int hi = 0, nbits = 0, rises = 0, first_rise = 0, last_rise = 0;
  int under_cyc = 0, done_cyc = 0, done_cnt = 0, under_cnt = 0, acc_cnt = 0;
  int ready_after_under = 0, gap_hi = 0;

  // Decode cells from the line, check cell pitch, and score each finished pixel.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_out    = 1'b0;
      hi          = 0;
      nbits       = 0;
      rises       = 0;
      after_under = 1'b0;
    end else begin
      if (pix_if.valid && pix_if.ready) acc_cnt++;
      if (after_under && pix_if.ready) ready_after_under++;
      if (after_under && out) gap_hi++;
      if (out && !prev_out) begin
        if (rises == 0) first_rise = cyc;
        else chk("cell_pitch", 32'(cyc - last_rise), 32'(TB));
        last_rise = cyc;
        rises++;
        hi = 1;
      end else if (out) begin
        hi++;
      end else if (prev_out) begin
        bitv = (hi == T1);
        if (hi != T0 && hi != T1) chk("high_time", 32'(hi), 32'(T0));
        word = {word[22:0], bitv};
        nbits++;
        if (nbits % 24 == 0) begin
          if (exp_q.size() == 0) chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
          else chk("pixel", 32'(word), 32'(exp_q.pop_front()));
        end
      end
      if (underrun) begin
        under_cnt++;
        under_cyc   = cyc;
        after_under = 1'b1;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 32'(busy), 0);
        rises       = 0;
        nbits       = 0;
        after_under = 1'b0;
      end
      prev_out = out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("ready_after_start", 32'(pix_if.ready), 1);
  endtask

  task automatic send_px(input logic [23:0] p);
    int n = 0;
    pix_if.data  = p;
    pix_if.valid = 1'b1;
    while (!pix_if.ready && n < 2000) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(pix_if.ready), 1);
    if (pix_if.ready) exp_q.push_back(model(p));
    tick();
    pix_if.valid = 1'b0;
  endtask

  task automatic wait_done();
    int d = done_cnt;
    int n = 0;
    while (done_cnt == d && n < 5000) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cnt - d), 1);
    chk("busy_after_done", 32'(busy), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_first_rise();
    int n = 0;
    while (rises == 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("first_rise_seen", 32'(rises != 0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, u0, d0, k;
    pix_if.valid = 1'b0;
    pix_if.data  = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out", 32'(out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(pix_if.ready), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_underrun", 32'(underrun), 0);

    // Basic frame.
    u0 = under_cnt;
    a0 = acc_cnt;
    start_frame();
    send_px(24'hFF0000);
    send_px(24'h00000F);
    wait_done();
    chk("basic_len", 32'(done_cyc - first_rise), 32'(FRAME_LEN));
    chk("basic_accepts", 32'(acc_cnt - a0), 32'(N));
    chk("basic_no_underrun", 32'(under_cnt - u0), 0);

    // Underrun: second pixel withheld.
    u0 = under_cnt;
    start_frame();
    send_px(24'h5A5A5A);
    wait_done();
    chk("ur_count", 32'(under_cnt - u0), 1);
    chk("ur_time", 32'(under_cyc - first_rise), 32'(24 * TB));
    chk("ur_gap_len", 32'(done_cyc - under_cyc), 32'(TR));
    chk("ur_ready_after", 32'(ready_after_under), 0);
    chk("ur_gap_out_high", 32'(gap_hi), 0);

    // Back-pressure: second pixel offered at cycle 200 of pixel 1.
    u0 = under_cnt;
    start_frame();
    send_px(24'hC33C81);
    wait_first_rise();
    k = 0;
    while (cyc < first_rise + 200 && k < 1000) begin
      tick();
      k++;
    end
    send_px(24'h7E0001);
    wait_done();
    chk("bp_len", 32'(done_cyc - first_rise), 32'(FRAME_LEN));
    chk("bp_no_underrun", 32'(under_cnt - u0), 0);

    // Reset in the middle of bit 5.
    start_frame();
    send_px(24'hFF0000);
    send_px(24'hFFFFFF);
    wait_first_rise();
    k = 0;
    while (cyc < first_rise + 5 * TB + 2 && k < 1000) begin
      tick();
      k++;
    end
    chk("pre_reset_out", 32'(out), 1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out", 32'(out), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ready", 32'(pix_if.ready), 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_no_done", 32'(done_cnt - d0), 0);
    start_frame();
    send_px(24'h123456);
    send_px(24'hA5C33C);
    wait_done();
    chk("post_reset_len", 32'(done_cyc - first_rise), 32'(FRAME_LEN));

    // START while busy is ignored; an extra pixel stays on offer throughout.
    a0 = acc_cnt;
    d0 = done_cnt;
    start_frame();
    send_px(24'h000000);
    send_px(24'hFFFFFF);
    pix_if.data  = 24'hABCDEF;
    pix_if.valid = 1'b1;
    k = 0;
    while (done_cnt == d0 && k < 5000) begin
      start = busy && (k % 7 == 3);
      tick();
      k++;
    end
    start = 1'b0;
    repeat (3) tick();
    chk("sb_done_once", 32'(done_cnt - d0), 1);
    chk("sb_accepts", 32'(acc_cnt - a0), 32'(N));
    chk("sb_len", 32'(done_cyc - first_rise), 32'(FRAME_LEN));
    chk("sb_idle_after", 32'(busy), 0);
    chk("sb_queue", 32'(exp_q.size()), 0);
    pix_if.valid = 1'b0;
    start_frame();
    send_px(24'h0F0F0F);
    send_px(24'hF0F0F0);
    wait_done();

    // Brightness (identity unless scaling is built in).
    bright = 8'd127;
    start_frame();
    send_px(24'hFF8001);
    send_px(24'h10FF80);
    wait_done();
    bright = 8'd255;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
